// File: rtl/rc_drive_sched.sv
// rc_drive_sched
//   Command scheduler between the UART receiver and the RC car drive outputs.
//   Decoded direction bytes ('w','a','s','d') are queued in a 4-entry FIFO.
//   Each command drives its LED/motor output for HOLD_CYCLES, followed by
//   GAP_CYCLES of dead time with all outputs low so the H-bridge never sees
//   two directions back to back. An 'x' byte stops everything immediately.
//
// Parameters
//   HOLD_CYCLES  cycles a command drives its output (>= 1)
//   GAP_CYCLES   dead-time cycles after each command (>= 1)
//
// Ports
//   clk_50    in   1  system clock
//   rst       in   1  synchronous reset, active high
//   rx_valid  in   1  one-cycle strobe, rx_data holds a received byte
//   rx_data   in   8  received byte
//   rx_ferr   in   1  framing error qualifier, byte discarded when set
//   led       out  4  one-hot or zero: [3]=fwd [2]=left [1]=rev [0]=right
//   busy      out  1  high while a command or its dead time is active
//   drop      out  1  one-cycle pulse per command lost to a full FIFO
//   level     out  3  FIFO occupancy, 0..4
//
// States
//   state  | meaning
//   S_IDLE | outputs low, waiting for a queued command
//   S_RUN  | driving one direction output for HOLD_CYCLES
//   S_GAP  | dead time, outputs low for GAP_CYCLES

module rc_drive_sched #(
    parameter int HOLD_CYCLES = 5_000_000,
    parameter int GAP_CYCLES  = 50_000
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_ferr,
    output logic [3:0] led,
    output logic       busy,
    output logic       drop,
    output logic [2:0] level
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Byte decode
    // ------------------------------------------------------------------
    logic       cmd_req;
    logic [1:0] cmd_code;
    logic       stop_req;

    always_comb begin
        cmd_req  = 1'b0;
        cmd_code = 2'd0;
        stop_req = 1'b0;
        if (rx_valid && !rx_ferr) begin
            case (rx_data)
                8'h77: begin cmd_req = 1'b1; cmd_code = 2'd3; end
                8'h61: begin cmd_req = 1'b1; cmd_code = 2'd2; end
                8'h73: begin cmd_req = 1'b1; cmd_code = 2'd1; end
                8'h64: begin cmd_req = 1'b1; cmd_code = 2'd0; end
                8'h78: stop_req = 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [1:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       fifo_empty;
    logic       fifo_full;
    logic       pop;
    logic       push_ok;
    logic [3:0] head_oh;

    assign fifo_empty = (count == 3'd0);
    assign fifo_full  = (count == 3'd4);

    // A full FIFO still accepts a command when the head leaves in the
    // same cycle, so a byte arriving exactly at a gap end is not lost.
    assign push_ok = cmd_req && (!fifo_full || pop);

    assign head_oh = 4'b0001 << fifo_mem[rd_ptr];

    always_ff @(posedge clk_50) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= cmd_code;
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else if (stop_req) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: ;
            endcase
        end
    end

    logic drop_q;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= cmd_req && !push_ok;
        end
    end

    // ------------------------------------------------------------------
    // Hold / dead-time sequencer
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      led_q, led_d;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            led_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                led_d = 4'b0000;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    led_d   = head_oh;
                    cnt_d   = HOLD_LOAD;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (cnt_q == '0) begin
                    led_d   = 4'b0000;
                    cnt_d   = GAP_LOAD;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_GAP: begin
                led_d = 4'b0000;
                if (cnt_q == '0) begin
                    // Chain straight into the next command so back-to-back
                    // commands see no extra idle cycle.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        led_d   = head_oh;
                        cnt_d   = HOLD_LOAD;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                led_d   = 4'b0000;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Emergency stop overrides everything, including a pending pop;
        // the FIFO flush discards the head anyway.
        if (stop_req) begin
            pop     = 1'b0;
            led_d   = 4'b0000;
            cnt_d   = '0;
            state_d = S_IDLE;
        end
    end

    assign led   = led_q;
    assign busy  = (state_q != S_IDLE);
    assign drop  = drop_q;
    assign level = count;

endmodule

// File: tb/tb_rc_drive_sched.sv
// Self-checking bench for rc_drive_sched with HOLD_CYCLES=20, GAP_CYCLES=3.
// Each scenario pushes its expected per-cycle outputs into a scoreboard
// queue as the stimulus is laid out; every cycle the front entries for that
// cycle are popped and compared against the DUT outputs.

module tb_rc_drive_sched;

    localparam int HOLD = 20;
    localparam int GAP  = 3;

    logic       clk_50 = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;
    logic [3:0] led;
    logic       busy;
    logic       drop;
    logic [2:0] level;

    always #10 clk_50 = ~clk_50;

    rc_drive_sched #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_50  (clk_50),
        .rst     (rst),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_ferr (rx_ferr),
        .led     (led),
        .busy    (busy),
        .drop    (drop),
        .level   (level)
    );

    typedef struct packed {
        logic [3:0] led;
        logic       busy;
        logic       drop;
        logic [2:0] level;
    } outs_t;

    typedef struct {
        int    cyc;
        outs_t val;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    string      tag    = "";
    logic [3:0] seq_oh [6];

    function automatic outs_t mk(logic [3:0] l, logic b, logic d, logic [2:0] lv);
        outs_t o;
        o.led   = l;
        o.busy  = b;
        o.drop  = d;
        o.level = lv;
        return o;
    endfunction

    function automatic logic in_rng(int c, int lo, int hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // led for n back-to-back commands, the first starting at cycle 2,
    // each taking HOLD cycles of drive plus GAP cycles of dead time.
    function automatic logic [3:0] led_seq(int c, int n);
        int k;
        int ph;
        if (c < 2) return 4'b0000;
        k  = (c - 2) / (HOLD + GAP);
        ph = (c - 2) % (HOLD + GAP);
        if (k < n && ph < HOLD) return seq_oh[k];
        return 4'b0000;
    endfunction

    task automatic expect_at(int c, outs_t v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        outs_t obs;
        exp_t  e;
        @(negedge clk_50);
        obs = mk(led, busy, drop, level);
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s cyc=%0d observed led=%b busy=%b drop=%b level=%0d expected led=%b busy=%b drop=%b level=%0d",
                       tag, cyc, obs.led, obs.busy, obs.drop, obs.level,
                       e.val.led, e.val.busy, e.val.drop, e.val.level);
            end
        end
        @(posedge clk_50);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_ferr  = 1'b0;
        rst      = 1'b0;
        cyc++;
    endtask

    task automatic send(logic [7:0] b, logic ferr);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_ferr  = ferr;
        tick();
    endtask

    task automatic run_until(int c);
        while (cyc < c) tick();
    endtask

    task automatic start_scn(string t);
        tag = t;
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk_50);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic end_scn();
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s_drain observed pending=%0d expected pending=0", tag, exp_q.size());
        end
    endtask

    initial begin
        logic [2:0] lv;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_ferr  = 1'b0;
        repeat (3) @(posedge clk_50);
        #1;

        // 1: single 'w'
        start_scn("single_w");
        for (int c = 0; c <= 30; c++)
            expect_at(c, mk(in_rng(c, 2, 21) ? 4'b1000 : 4'b0000,
                            in_rng(c, 2, 24), 1'b0, (c == 1) ? 3'd1 : 3'd0));
        send(8'h77, 1'b0);
        run_until(31);
        end_scn();

        // 2: 'w' then 'a' queued during the first hold
        start_scn("w_then_a");
        for (int c = 0; c <= 50; c++) begin
            expect_at(c, mk(in_rng(c, 2, 21) ? 4'b1000 :
                            in_rng(c, 25, 44) ? 4'b0100 : 4'b0000,
                            in_rng(c, 2, 47), 1'b0,
                            (c == 1 || in_rng(c, 13, 24)) ? 3'd1 : 3'd0));
        end
        send(8'h77, 1'b0);
        run_until(12);
        send(8'h61, 1'b0);
        run_until(51);
        end_scn();

        // 3: burst of six, last one dropped on a full FIFO
        start_scn("burst_drop");
        seq_oh[0] = 4'b1000; seq_oh[1] = 4'b0100; seq_oh[2] = 4'b0010;
        seq_oh[3] = 4'b0001; seq_oh[4] = 4'b1000; seq_oh[5] = 4'b0000;
        for (int c = 0; c <= 125; c++) begin
            if      (c == 0)  lv = 3'd0;
            else if (c == 1)  lv = 3'd1;
            else if (c == 2)  lv = 3'd0;
            else if (c <= 4)  lv = 3'd1;
            else if (c <= 6)  lv = 3'd2;
            else if (c <= 8)  lv = 3'd3;
            else if (c <= 24) lv = 3'd4;
            else if (c <= 47) lv = 3'd3;
            else if (c <= 70) lv = 3'd2;
            else if (c <= 93) lv = 3'd1;
            else              lv = 3'd0;
            expect_at(c, mk(led_seq(c, 5), in_rng(c, 2, 116), (c == 11), lv));
        end
        send(8'h77, 1'b0); tick();
        send(8'h61, 1'b0); tick();
        send(8'h73, 1'b0); tick();
        send(8'h64, 1'b0); tick();
        send(8'h77, 1'b0); tick();
        send(8'h61, 1'b0);
        run_until(126);
        end_scn();

        // 4: emergency stop mid-RUN
        start_scn("stop_mid_run");
        for (int c = 0; c <= 111; c++) begin
            if      (c == 1)           lv = 3'd1;
            else if (in_rng(c, 3, 4)) lv = 3'd1;
            else if (in_rng(c, 5, 10)) lv = 3'd2;
            else                       lv = 3'd0;
            expect_at(c, mk(in_rng(c, 2, 10) ? 4'b1000 : 4'b0000,
                            in_rng(c, 2, 10), 1'b0, lv));
        end
        send(8'h77, 1'b0); tick();
        send(8'h61, 1'b0); tick();
        send(8'h73, 1'b0);
        run_until(10);
        send(8'h78, 1'b0);
        run_until(112);
        end_scn();

        // 5: non-command bytes and a framing-error byte are ignored
        start_scn("ignored_bytes");
        for (int c = 0; c <= 12; c++)
            expect_at(c, mk(4'b0000, 1'b0, 1'b0, 3'd0));
        send(8'h41, 1'b0); tick();
        send(8'h57, 1'b0); tick();
        send(8'h77, 1'b1);
        run_until(13);
        end_scn();

        // 6: reset mid-operation
        start_scn("reset_mid_run");
        for (int c = 0; c <= 40; c++) begin
            expect_at(c, mk(in_rng(c, 2, 10) ? 4'b1000 : 4'b0000,
                            in_rng(c, 2, 10), 1'b0,
                            (c == 1 || in_rng(c, 3, 10)) ? 3'd1 : 3'd0));
        end
        send(8'h77, 1'b0); tick();
        send(8'h61, 1'b0);
        run_until(10);
        rst = 1'b1;
        tick();
        run_until(41);
        end_scn();

        // 7: push into a full FIFO in the same cycle as a pop is accepted
        start_scn("full_push_pop");
        seq_oh[0] = 4'b1000; seq_oh[1] = 4'b0100; seq_oh[2] = 4'b0010;
        seq_oh[3] = 4'b0001; seq_oh[4] = 4'b1000; seq_oh[5] = 4'b0001;
        for (int c = 0; c <= 145; c++) begin
            if      (c == 0)   lv = 3'd0;
            else if (c == 1)   lv = 3'd1;
            else if (c == 2)   lv = 3'd0;
            else if (c <= 4)   lv = 3'd1;
            else if (c <= 6)   lv = 3'd2;
            else if (c <= 8)   lv = 3'd3;
            else if (c <= 47)  lv = 3'd4;
            else if (c <= 70)  lv = 3'd3;
            else if (c <= 93)  lv = 3'd2;
            else if (c <= 116) lv = 3'd1;
            else               lv = 3'd0;
            expect_at(c, mk(led_seq(c, 6), in_rng(c, 2, 139), 1'b0, lv));
        end
        send(8'h77, 1'b0); tick();
        send(8'h61, 1'b0); tick();
        send(8'h73, 1'b0); tick();
        send(8'h64, 1'b0); tick();
        send(8'h77, 1'b0);
        run_until(24);
        send(8'h64, 1'b0);
        run_until(146);
        end_scn();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
